// File: rtl/game_pkg.sv
// Shared constants and types for the whac-a-mole input path and game FSM.
package game_pkg;

  localparam int unsigned NUM_SW            = 10;
  localparam int unsigned CLK_HZ            = 50000000;
  localparam int unsigned DB_CYCLES_DEFAULT = CLK_HZ / 100;

  typedef logic [NUM_SW-1:0] sw_vec_t;

endpackage

// File: rtl/switch_conditioner_if.sv
// Switch conditioner bus: raw switches and game tick in, conditioned levels/pulses/snapshot out.
// Optional sw_fall signal is present only when SW_FALL_EN is defined.
interface switch_conditioner_if #(
  parameter int unsigned NUM_SW = game_pkg::NUM_SW
);

  logic [NUM_SW-1:0] sw;
  logic              tick;
  logic [NUM_SW-1:0] sw_level;
  logic [NUM_SW-1:0] sw_rise;
  logic [NUM_SW-1:0] sw_hits;
  logic              hit_any;
`ifdef SW_FALL_EN
  logic [NUM_SW-1:0] sw_fall;
`endif

  modport master (
    output sw, tick,
    input  sw_level, sw_rise, sw_hits, hit_any
`ifdef SW_FALL_EN
    , input sw_fall
`endif
  );

  modport slave (
    input  sw, tick,
    output sw_level, sw_rise, sw_hits, hit_any
`ifdef SW_FALL_EN
    , output sw_fall
`endif
  );

endinterface

// File: rtl/sw_debounce_bit.sv
// One switch channel: 2-flop synchroniser, stable-sample debouncer, registered edge pulses.
// sw_fall output exists only when SW_FALL_EN is defined.
module sw_debounce_bit #(
  parameter int unsigned DB_CYCLES = game_pkg::DB_CYCLES_DEFAULT
) (
  input  logic clock,
  input  logic reset,
  input  logic sw,
  output logic level,
  output logic rise
`ifdef SW_FALL_EN
  , output logic fall
`endif
);

  localparam int unsigned CW = (DB_CYCLES > 1) ? $clog2(DB_CYCLES) : 1;
  localparam logic [CW-1:0] LAST = CW'(DB_CYCLES - 1);

  logic          s1;
  logic          s2;
  logic [CW-1:0] count;
  logic          accept_c;

  assign accept_c = (s2 != level) && (count == LAST);

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      s1 <= 1'b0;
      s2 <= 1'b0;
    end else begin
      s1 <= sw;
      s2 <= s1;
    end
  end

  // Pulses are set on the same edge that updates level so they line up with it.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      count <= '0;
      level <= 1'b0;
      rise  <= 1'b0;
    end else begin
      rise <= accept_c & s2;
      if (s2 == level) begin
        count <= '0;
      end else if (accept_c) begin
        level <= s2;
        count <= '0;
      end else begin
        count <= count + CW'(1);
      end
    end
  end

`ifdef SW_FALL_EN
  always_ff @(posedge clock or posedge reset) begin
    if (reset) fall <= 1'b0;
    else       fall <= accept_c & ~s2;
  end
`endif

endmodule

// File: rtl/switch_conditioner.sv
// Switch input stage: per-channel sync/debounce plus a hit snapshot held between game ticks.
// Define SW_FALL_EN to add the sw_fall pulse output.
module switch_conditioner
  import game_pkg::*;
#(
  parameter int unsigned NUM_SW    = game_pkg::NUM_SW,
  parameter int unsigned DB_CYCLES = game_pkg::DB_CYCLES_DEFAULT
) (
  input  logic               clock,
  input  logic               reset,
  switch_conditioner_if.slave bus
);

  logic [NUM_SW-1:0] level;
  logic [NUM_SW-1:0] rise;
  logic [NUM_SW-1:0] pend;
  logic [NUM_SW-1:0] hits;
  logic              any_hit;
`ifdef SW_FALL_EN
  logic [NUM_SW-1:0] fall;
`endif

  for (genvar i = 0; i < NUM_SW; i++) begin : g_ch
    sw_debounce_bit #(.DB_CYCLES(DB_CYCLES)) u_db (
      .clock (clock),
      .reset (reset),
      .sw    (bus.sw[i]),
      .level (level[i]),
      .rise  (rise[i])
`ifdef SW_FALL_EN
      , .fall (fall[i])
`endif
    );
  end

  // A rise coincident with tick lands in this snapshot and is not carried into pend.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      pend    <= '0;
      hits    <= '0;
      any_hit <= 1'b0;
    end else if (bus.tick) begin
      hits    <= pend | rise;
      any_hit <= |(pend | rise);
      pend    <= '0;
    end else begin
      pend    <= pend | rise;
    end
  end

  assign bus.sw_level = level;
  assign bus.sw_rise  = rise;
  assign bus.sw_hits  = hits;
  assign bus.hit_any  = any_hit;
`ifdef SW_FALL_EN
  assign bus.sw_fall  = fall;
`endif

endmodule

// File: tb/tb_switch_conditioner.sv
// Self-checking bench for switch_conditioner: directed vector table, reset corners, random vs model.
module tb_switch_conditioner;
  import game_pkg::*;

  localparam int unsigned N  = game_pkg::NUM_SW;
  localparam int unsigned DB = 4;

  logic clock = 1'b0;
  logic reset;
  int   total = 0;
  int   bad   = 0;

  always #5 clock = ~clock;

  switch_conditioner_if #(.NUM_SW(N)) bus ();

  switch_conditioner #(.NUM_SW(N), .DB_CYCLES(DB)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus.slave)
  );

  typedef struct {
    sw_vec_t sw;
    logic    tick;
    sw_vec_t lvl;
    sw_vec_t rise;
    sw_vec_t hits;
    logic    any;
  } vec_t;

  vec_t tbl[$];

  // Reference model state: sync pipeline, window of recent synchronised samples, hit bookkeeping.
  sw_vec_t m_s1, m_s2, m_lvl, m_rise, m_fall, m_pend, m_hits;
  logic    m_any;
  sw_vec_t m_hist[$];

  function automatic logic [31:0] pack(input sw_vec_t l, input sw_vec_t r, input sw_vec_t h, input logic a);
    return {1'b0, l, r, h, a};
  endfunction

  function automatic logic [31:0] obs();
    return pack(bus.sw_level, bus.sw_rise, bus.sw_hits, bus.hit_any);
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got lvl/rise/hits/any=%h want %h", name, act, exp);
    end
  endtask

  task automatic add(input sw_vec_t s, input logic t, input sw_vec_t l, input sw_vec_t r,
                     input sw_vec_t h, input logic a, input int n = 1);
    vec_t v;
    v.sw = s; v.tick = t; v.lvl = l; v.rise = r; v.hits = h; v.any = a;
    repeat (n) tbl.push_back(v);
  endtask

  task automatic model_reset();
    m_s1 = '0; m_s2 = '0; m_lvl = '0; m_rise = '0; m_fall = '0;
    m_pend = '0; m_hits = '0; m_any = 1'b0;
    m_hist.delete();
  endtask

  // A level flips once the last DB synchronised samples all disagree with it.
  task automatic model_step(input sw_vec_t s, input logic t);
    sw_vec_t nr, nf;
    if (t) begin
      m_hits = m_pend | m_rise;
      m_any  = |(m_pend | m_rise);
      m_pend = '0;
    end else begin
      m_pend = m_pend | m_rise;
    end
    m_hist.push_back(m_s2);
    if (m_hist.size() > int'(DB)) void'(m_hist.pop_front());
    nr = '0; nf = '0;
    for (int i = 0; i < int'(N); i++) begin
      bit flip;
      flip = (m_hist.size() == int'(DB));
      foreach (m_hist[k]) if (m_hist[k][i] == m_lvl[i]) flip = 1'b0;
      if (flip) begin
        m_lvl[i] = ~m_lvl[i];
        nr[i] = m_lvl[i];
        nf[i] = ~m_lvl[i];
      end
    end
    m_rise = nr;
    m_fall = nf;
    m_s2 = m_s1;
    m_s1 = s;
  endtask

  initial begin
    sw_vec_t s;

    // Reset with all switches high clears outputs before any clock edge.
    reset = 1'b1;
    bus.sw = 10'h3FF;
    bus.tick = 1'b0;
    #2;
    check("reset_async", obs(), 32'h0);
    repeat (3) @(negedge clock);
    check("reset_hold", obs(), 32'h0);
    reset = 1'b0;
    bus.sw = '0;

    // Directed vectors, one row per clock: inputs before the edge, outputs after it.
    add(10'h014, 0, 10'h000, 10'h000, 10'h000, 0, 3);
    add(10'h004, 0, 10'h000, 10'h000, 10'h000, 0, 2);
    add(10'h004, 0, 10'h004, 10'h004, 10'h000, 0);
    add(10'h004, 0, 10'h004, 10'h000, 10'h000, 0);
    add(10'h004, 1, 10'h004, 10'h000, 10'h004, 1);
    add(10'h004, 1, 10'h004, 10'h000, 10'h000, 0);
    add(10'h026, 0, 10'h004, 10'h000, 10'h000, 0, 5);
    add(10'h026, 0, 10'h026, 10'h022, 10'h000, 0);
    add(10'h026, 0, 10'h026, 10'h000, 10'h000, 0);
    add(10'h026, 1, 10'h026, 10'h000, 10'h022, 1);
    add(10'h026, 0, 10'h026, 10'h000, 10'h022, 1);
    add(10'h026, 1, 10'h026, 10'h000, 10'h000, 0);
    add(10'h0A6, 0, 10'h026, 10'h000, 10'h000, 0, 5);
    add(10'h0A6, 0, 10'h0A6, 10'h080, 10'h000, 0);
    add(10'h0A6, 1, 10'h0A6, 10'h000, 10'h080, 1);
    add(10'h0A6, 0, 10'h0A6, 10'h000, 10'h080, 1);
    add(10'h0A6, 1, 10'h0A6, 10'h000, 10'h000, 0);
    add(10'h0A4, 0, 10'h0A6, 10'h000, 10'h000, 0, 5);
    add(10'h0A4, 0, 10'h0A4, 10'h000, 10'h000, 0);
    add(10'h0A4, 1, 10'h0A4, 10'h000, 10'h000, 0);

    foreach (tbl[k]) begin
      bus.sw = tbl[k].sw;
      bus.tick = tbl[k].tick;
      @(negedge clock);
      check($sformatf("vec%0d", k), obs(), pack(tbl[k].lvl, tbl[k].rise, tbl[k].hits, tbl[k].any));
    end

    // Reset mid-count on sw[3], release with switches held high.
    bus.tick = 1'b0;
    bus.sw = 10'h0AC;
    repeat (4) @(negedge clock);
    check("pre_reset", obs(), pack(10'h0A4, 10'h000, 10'h000, 1'b0));
    reset = 1'b1;
    #1;
    check("reset_mid", obs(), 32'h0);
    @(negedge clock);
    reset = 1'b0;
    for (int e = 1; e <= 7; e++) begin
      @(negedge clock);
      check($sformatf("post_rel_e%0d", e), obs(),
            pack((e >= 6) ? 10'h0AC : 10'h000, (e == 6) ? 10'h0AC : 10'h000, 10'h000, 1'b0));
    end

    // Random stimulus against the reference model.
    @(negedge clock);
    reset = 1'b1;
    model_reset();
    @(negedge clock);
    reset = 1'b0;
    s = '0;
    for (int i = 0; i < 2000; i++) begin
      if (i == 1000) begin
        reset = 1'b1;
        model_reset();
        #1;
        check("rand_reset", obs(), 32'h0);
        @(negedge clock);
        reset = 1'b0;
      end
      if ($urandom_range(0, 3) == 0) s[$urandom_range(0, N - 1)] ^= 1'b1;
      bus.sw = s;
      bus.tick = ($urandom_range(0, 5) == 0);
      @(posedge clock);
      model_step(bus.sw, bus.tick);
      @(negedge clock);
      check($sformatf("rand%0d", i), obs(), pack(m_lvl, m_rise, m_hits, m_any));
`ifdef SW_FALL_EN
      check($sformatf("rand_fall%0d", i), {22'h0, bus.sw_fall}, {22'h0, m_fall});
`endif
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
